// File: rtl/dps29_enc_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dps29_enc_scheduler_pkg
//  Purpose  : Shared constants for the 29-bit DPS encoder scheduler.
//             - DBLEN29     : data word width fed to the encoder
//             - CODEW29     : codeword width on the TSV/bus side
//             - DPS29_RANGE : number of encodable values (F(31))
//             - FNS_W       : Fibonacci digit weights, LSB first
//             - SCH_*       : scheduler FSM state encodings
//  Revision : 1.0  initial release
// ============================================================================
package dps29_enc_scheduler_pkg;

  localparam int DBLEN29 = 21;
  localparam int CODEW29 = 29;

  // A 29-digit Fibonacci numeral with no two adjacent ones covers 0..F(31)-1.
  localparam logic [DBLEN29-1:0] DPS29_RANGE = 21'd1346269;

  // Digit k carries weight F(k+2): 1, 2, 3, 5, 8, ...
  localparam logic [DBLEN29-1:0] FNS_W [CODEW29] = '{
    21'd1,      21'd2,      21'd3,      21'd5,      21'd8,
    21'd13,     21'd21,     21'd34,     21'd55,     21'd89,
    21'd144,    21'd233,    21'd377,    21'd610,    21'd987,
    21'd1597,   21'd2584,   21'd4181,   21'd6765,   21'd10946,
    21'd17711,  21'd28657,  21'd46368,  21'd75025,  21'd121393,
    21'd196418, 21'd317811, 21'd514229, 21'd832040
  };

  typedef logic [1:0] sch_state_t;

  localparam logic [1:0] SCH_IDLE = 2'd0;
  localparam logic [1:0] SCH_ENC  = 2'd1;
  localparam logic [1:0] SCH_OUT  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/DPS_encoder_29.sv
`default_nettype none
// ============================================================================
//  Module   : DPS_encoder_29
//  Purpose  : Registered Fibonacci-numeral (Zeckendorf) encoder. Every rising
//             edge captures the encoding of datain; there is no enable and no
//             reset, so codeout is meaningful one cycle after datain settles.
//  Ports    : clock   in   rising-edge clock
//             datain  in   DBLEN29-bit binary word, must be < DPS29_RANGE
//             codeout out  CODEW29-bit codeword, no two adjacent ones
//  Revision : 1.0  initial release
// ============================================================================
module DPS_encoder_29
  import dps29_enc_scheduler_pkg::*;
(
  input  logic               clock,
  input  logic [DBLEN29-1:0] datain,
  output logic [CODEW29-1:0] codeout
);

  logic [CODEW29-1:0] code_d;
  logic [CODEW29-1:0] code_q;
  logic [DBLEN29-1:0] rem;

  // Greedy MSB-first digit extraction; taking the largest weight that fits
  // guarantees the next lower digit is zero, which is the crosstalk property.
  always_comb begin
    rem    = datain;
    code_d = '0;
    for (int k = CODEW29 - 1; k >= 0; k--) begin
      if (rem >= FNS_W[k]) begin
        code_d[k] = 1'b1;
        rem       = rem - FNS_W[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    code_q <= code_d;
  end

  assign codeout = code_q;

endmodule
`default_nettype wire

// File: rtl/dps29_enc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dps29_enc_scheduler
//  Purpose  : Round-robin sharing of one registered DPS_encoder_29 between
//             NREQ requesters, with range checking and a valid/ready output.
//  Ports    : clock, reset_n          clock, synchronous active-low reset
//             req_valid/req_data      per-requester words (DBLEN29 each)
//             req_ready               one-hot combinational accept strobe
//             out_valid/out_ready     codeword handshake
//             out_code/out_id         codeword and its source requester
//             err_valid/err_id        1-cycle pulse for a dropped word
//             busy                    FSM not idle
//  Revision : 1.0  initial release
// ============================================================================
module dps29_enc_scheduler
  import dps29_enc_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DBLEN29-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CODEW29-1:0]      out_code,
  output logic [IDW-1:0]          out_id,
  output logic                    err_valid,
  output logic [IDW-1:0]          err_id,
  output logic                    busy
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  sch_state_t         state_q,     state_d;
  logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [DBLEN29-1:0] data_q,      data_d;
  logic [IDW-1:0]     id_q,        id_d;
  logic [IDW-1:0]     out_id_q,    out_id_d;
  logic               err_valid_q, err_valid_d;
  logic [IDW-1:0]     err_id_q,    err_id_d;

  logic               grant_opp;
  logic               grant_found;
  logic               grant;
  logic [IDW-1:0]     grant_idx;
  logic [IDW:0]       cand;
  logic [IDW:0]       nxt_ptr;
  logic [DBLEN29-1:0] word;
  logic               in_range;

  // A new word may only be taken when the encoder path is free: idle, or the
  // current codeword is leaving this very cycle.
  assign grant_opp = (state_q == SCH_IDLE) || ((state_q == SCH_OUT) && out_ready);

  // Round-robin search starting at rr_ptr; the wrap is at NREQ, not 2^IDW.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(off);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign grant    = grant_opp && grant_found;
  assign word     = req_data[int'(grant_idx)*DBLEN29 +: DBLEN29];
  assign in_range = (word < DPS29_RANGE);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    data_d      = data_q;
    id_d        = id_q;
    out_id_d    = out_id_q;
    err_valid_d = 1'b0;
    err_id_d    = err_id_q;
    nxt_ptr     = {1'b0, grant_idx} + {{IDW{1'b0}}, 1'b1};
    if (nxt_ptr == NREQ_W) nxt_ptr = '0;

    case (state_q)
      SCH_IDLE: state_d = (grant && in_range) ? SCH_ENC : SCH_IDLE;
      SCH_ENC:  state_d = SCH_OUT;
      SCH_OUT:  if (out_ready) state_d = (grant && in_range) ? SCH_ENC : SCH_IDLE;
      default:  state_d = SCH_IDLE;
    endcase

    // Dropped words still advance the pointer so a faulty requester cannot
    // monopolise the arbiter.
    if (grant) begin
      rr_ptr_d = nxt_ptr[IDW-1:0];
      if (in_range) begin
        data_d = word;
        id_d   = grant_idx;
      end else begin
        err_valid_d = 1'b1;
        err_id_d    = grant_idx;
      end
    end

    // The encoder captures data_q on the ENC->OUT edge; the ID follows it.
    if (state_q == SCH_ENC) out_id_d = id_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= SCH_IDLE;
      rr_ptr_q    <= '0;
      data_q      <= '0;
      id_q        <= '0;
      out_id_q    <= '0;
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      data_q      <= data_d;
      id_q        <= id_d;
      out_id_q    <= out_id_d;
      err_valid_q <= err_valid_d;
      err_id_q    <= err_id_d;
    end
  end

  DPS_encoder_29 u_enc (
    .clock   (clock),
    .datain  (data_q),
    .codeout (out_code)
  );

  assign out_valid = (state_q == SCH_OUT);
  assign out_id    = out_id_q;
  assign err_valid = err_valid_q;
  assign err_id    = err_id_q;
  assign busy      = (state_q != SCH_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dps29_enc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dps29_enc_scheduler
//  Purpose  : Directed scoreboard bench for dps29_enc_scheduler (NREQ=4 and
//             NREQ=3 instances). Expected codewords are hand-computed
//             Zeckendorf codes over weights 1,2,3,5,8,...
//  Revision : 1.0  initial release
// ============================================================================
module tb_dps29_enc_scheduler;
  import dps29_enc_scheduler_pkg::*;

  typedef struct packed {
    logic [1:0]  id;
    logic [28:0] code;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n = 1'b0;
  int   cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // NREQ = 4 instance
  logic [3:0]           rv4 = '0;
  logic [4*DBLEN29-1:0] rd4 = '0;
  logic [3:0]           rr4;
  logic                 ov4, ev4, busy4;
  logic                 ordy4 = 1'b1;
  logic [28:0]          oc4;
  logic [1:0]           oid4, eid4;

  // NREQ = 3 instance
  logic [2:0]           rv3 = '0;
  logic [3*DBLEN29-1:0] rd3 = '0;
  logic [2:0]           rr3;
  logic                 ov3, ev3, busy3;
  logic                 ordy3 = 1'b1;
  logic [28:0]          oc3;
  logic [1:0]           oid3, eid3;

  dps29_enc_scheduler #(.NREQ(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .req_valid(rv4), .req_data(rd4),
    .req_ready(rr4), .out_valid(ov4), .out_ready(ordy4), .out_code(oc4),
    .out_id(oid4), .err_valid(ev4), .err_id(eid4), .busy(busy4)
  );

  dps29_enc_scheduler #(.NREQ(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .req_valid(rv3), .req_data(rd3),
    .req_ready(rr3), .out_valid(ov3), .out_ready(ordy3), .out_code(oc3),
    .out_id(oid3), .err_valid(ev3), .err_id(eid3), .busy(busy3)
  );

  int tests = 0;
  int fails = 0;

  exp_t       exp4[$];
  exp_t       exp3[$];
  logic [1:0] errq4[$];
  logic [1:0] errq3[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event, value 0x%0h, nothing expected (t=%0t)", nm, act, $time);
  endtask

  // Monitors: pop and compare whenever the DUT presents a result.
  always @(negedge clock) begin
    if (reset_n) begin
      if (ov4 && ordy4) begin
        if (exp4.size() == 0) unexpected("out4", {1'b0, oid4, oc4});
        else begin
          exp_t e;
          e = exp4.pop_front();
          chk("out4_id", 32'(oid4), 32'(e.id));
          chk("out4_code", 32'(oc4), 32'(e.code));
        end
      end
      if (ev4) begin
        if (errq4.size() == 0) unexpected("err4", 32'(eid4));
        else chk("err4_id", 32'(eid4), 32'(errq4.pop_front()));
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (ov3 && ordy3) begin
        if (exp3.size() == 0) unexpected("out3", {1'b0, oid3, oc3});
        else begin
          exp_t e;
          e = exp3.pop_front();
          chk("out3_id", 32'(oid3), 32'(e.id));
          chk("out3_code", 32'(oc3), 32'(e.code));
        end
      end
      if (ev3) begin
        if (errq3.size() == 0) unexpected("err3", 32'(eid3));
        else chk("err3_id", 32'(eid3), 32'(errq3.pop_front()));
      end
    end
  end

  // Wait (bounded) for a grant and check which requester got it.
  task automatic grant4(input string nm, input logic [3:0] exp_rdy);
    int c = 0;
    @(negedge clock);
    while (rr4 == 4'b0 && c < 20) begin
      @(negedge clock);
      c++;
    end
    chk(nm, 32'(rr4), 32'(exp_rdy));
  endtask

  task automatic grant3(input string nm, input logic [2:0] exp_rdy);
    int c = 0;
    @(negedge clock);
    while (rr3 == 3'b0 && c < 20) begin
      @(negedge clock);
      c++;
    end
    chk(nm, 32'(rr3), 32'(exp_rdy));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rv4 = '0;
    rv3 = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic next_drive();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [28:0] rr_code [4];
    int          order [5];
    int          last;
    rr_code = '{29'h1, 29'h2, 29'h4, 29'h5};
    order   = '{0, 1, 2, 3, 0};

    // ---------------- reset values ----------------
    do_reset();
    @(negedge clock);
    chk("rst_out_valid", 32'(ov4), 0);
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_err_valid", 32'(ev4), 0);
    chk("rst_req_ready", 32'(rr4), 0);
    chk("rst_out_id", 32'(oid4), 0);
    chk("rst_err_id", 32'(eid4), 0);
    chk("rst_rr_ptr", 32'(u_dut4.rr_ptr_q), 0);

    // ---------------- single word: req 2 sends 5 ----------------
    next_drive();
    ordy4 = 1'b1;
    rd4[2*DBLEN29 +: DBLEN29] = 21'd5;
    rv4 = 4'b0100;
    grant4("single_grant", 4'b0100);
    exp4.push_back('{id: 2'd2, code: 29'h8});
    next_drive();
    rv4 = '0;
    @(negedge clock);
    chk("single_enc_busy", 32'(busy4), 1);
    chk("single_enc_ovalid", 32'(ov4), 0);
    @(negedge clock);
    chk("single_out_valid", 32'(ov4), 1);
    chk("single_rr_ptr", 32'(u_dut4.rr_ptr_q), 3);

    // ---------------- round robin, all four valid ----------------
    next_drive();
    do_reset();
    rd4 = {21'd4, 21'd3, 21'd2, 21'd1};
    rv4 = 4'b1111;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      grant4($sformatf("rr_grant%0d", g), 4'(1 << order[g]));
      if (g > 0) chk($sformatf("rr_spacing%0d", g), 32'(cyc - last), 2);
      last = cyc;
      exp4.push_back('{id: 2'(order[g]), code: rr_code[order[g]]});
      next_drive();
      if (g == 4) rv4 = '0;
    end
    repeat (4) @(negedge clock);

    // ---------------- backpressure ----------------
    next_drive();
    ordy4 = 1'b0;
    rd4[3*DBLEN29 +: DBLEN29] = 21'd100;
    rd4[0 +: DBLEN29]         = 21'd7;
    rv4 = 4'b1001;
    grant4("bp_first_grant", 4'b1000);
    exp4.push_back('{id: 2'd3, code: 29'h214});
    next_drive();
    rv4 = 4'b0001;
    @(negedge clock);
    chk("bp_enc_no_grant", 32'(rr4), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk($sformatf("bp_hold_valid%0d", i), 32'(ov4), 1);
      chk($sformatf("bp_hold_code%0d", i), 32'(oc4), 32'h214);
      chk($sformatf("bp_hold_id%0d", i), 32'(oid4), 3);
      chk($sformatf("bp_hold_rdy%0d", i), 32'(rr4), 0);
    end
    next_drive();
    ordy4 = 1'b1;
    @(negedge clock);
    chk("bp_release_grant", 32'(rr4), 32'b0001);
    exp4.push_back('{id: 2'd0, code: 29'hA});
    next_drive();
    rv4 = '0;
    repeat (3) @(negedge clock);

    // ---------------- range check ----------------
    next_drive();
    rd4[1*DBLEN29 +: DBLEN29] = DPS29_RANGE;
    rv4 = 4'b0010;
    grant4("range_grant", 4'b0010);
    errq4.push_back(2'd1);
    next_drive();
    rv4 = '0;
    @(negedge clock);
    chk("range_err_valid", 32'(ev4), 1);
    chk("range_err_id", 32'(eid4), 1);
    chk("range_no_out", 32'(ov4), 0);
    chk("range_idle", 32'(busy4), 0);
    @(negedge clock);
    chk("range_err_pulse_end", 32'(ev4), 0);

    // back-to-back bad words: rr_ptr is 2, so requester 2 goes first
    next_drive();
    rd4[1*DBLEN29 +: DBLEN29] = 21'h1FFFFF;
    rd4[2*DBLEN29 +: DBLEN29] = DPS29_RANGE;
    rv4 = 4'b0110;
    grant4("b2b_grant_a", 4'b0100);
    errq4.push_back(2'd2);
    next_drive();
    rv4 = 4'b0010;
    @(negedge clock);
    chk("b2b_grant_b", 32'(rr4), 32'b0010);
    chk("b2b_err_a", 32'(ev4), 1);
    errq4.push_back(2'd1);
    next_drive();
    rv4 = '0;
    @(negedge clock);
    chk("b2b_err_b", 32'(ev4), 1);
    chk("b2b_err_b_id", 32'(eid4), 1);
    @(negedge clock);
    chk("b2b_err_end", 32'(ev4), 0);

    // largest encodable value
    next_drive();
    rd4[1*DBLEN29 +: DBLEN29] = DPS29_RANGE - 21'd1;
    rv4 = 4'b0010;
    grant4("max_grant", 4'b0010);
    exp4.push_back('{id: 2'd1, code: 29'h15555555});
    next_drive();
    rv4 = '0;
    repeat (3) @(negedge clock);

    // ---------------- reset while in ENC ----------------
    next_drive();
    rd4[3*DBLEN29 +: DBLEN29] = 21'd4;
    rv4 = 4'b1000;
    grant4("rst_enc_grant", 4'b1000);
    next_drive();
    rv4 = '0;
    @(negedge clock);
    chk("rst_enc_busy_before", 32'(busy4), 1);
    reset_n = 1'b0;
    next_drive();
    @(negedge clock);
    chk("rst_enc_busy_after", 32'(busy4), 0);
    chk("rst_enc_ovalid_after", 32'(ov4), 0);
    chk("rst_enc_no_err", 32'(ev4), 0);
    rd4[1*DBLEN29 +: DBLEN29] = 21'd6;
    rd4[2*DBLEN29 +: DBLEN29] = 21'd3;
    rv4 = 4'b0110;
    next_drive();
    reset_n = 1'b1;
    grant4("post_rst_grant", 4'b0010);
    exp4.push_back('{id: 2'd1, code: 29'h9});
    next_drive();
    rv4 = '0;
    repeat (3) @(negedge clock);

    // ---------------- NREQ = 3: data 0 and wrap 2 -> 0 ----------------
    next_drive();
    ordy3 = 1'b1;
    rd3[2*DBLEN29 +: DBLEN29] = 21'd0;
    rv3 = 3'b100;
    grant3("n3_grant2", 3'b100);
    exp3.push_back('{id: 2'd2, code: 29'h0});
    next_drive();
    rv3 = '0;
    @(negedge clock);
    chk("n3_rr_wrap", 32'(u_dut3.rr_ptr_q), 0);
    next_drive();
    rd3[0 +: DBLEN29]         = 21'd10;
    rd3[2*DBLEN29 +: DBLEN29] = 21'd2;
    rv3 = 3'b101;
    grant3("n3_grant0", 3'b001);
    exp3.push_back('{id: 2'd0, code: 29'h12});
    next_drive();
    rv3 = 3'b100;
    grant3("n3_grant2b", 3'b100);
    exp3.push_back('{id: 2'd2, code: 29'h2});
    next_drive();
    rv3 = '0;
    repeat (4) @(negedge clock);

    chk("exp4_drained", 32'(exp4.size()), 0);
    chk("err4_drained", 32'(errq4.size()), 0);
    chk("exp3_drained", 32'(exp3.size()), 0);
    chk("err3_drained", 32'(errq3.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dps29_enc_scheduler.md
# dps29_enc_scheduler

Shares one 29-bit DPS (Fibonacci-numeral crosstalk-avoidance) encoder between `NREQ` upstream requesters. Round-robin arbitration with per-requester valid/ready handshakes. Range-checks each accepted word and steers it through the registered encoder, which has no enable. Presents the resulting 29-bit codeword with the requester ID on a single valid/ready output toward the TSV/bus driver.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `IDW`, 2, requester-ID width, `$clog2(NREQ)`
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `req_valid`  in  NREQ  per-requester word valid
- `req_data`  in  NREQ*`DBLEN29`  requester i in slice [i*`DBLEN29` +: `DBLEN29`]
- `req_ready`  out  NREQ  one-hot accept strobe, combinational
- `out_valid`  out  1  codeword valid
- `out_ready`  in  1  downstream accept
- `out_code`  out  29  encoded word
- `out_id`  out  IDW  source requester of `out_code`
- `err_valid`  out  1  one-cycle pulse, out-of-range word dropped
- `err_id`  out  IDW  source of dropped word
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ENC, OUT. Registers:
  - `state`
  - `rr_ptr` (IDW bits)
  - `data_q` (`DBLEN29` bits, drives encoder `datain`)
  - `id_q`, `out_id`
  - `err_valid`, `err_id`
- Grant opportunity: state IDLE, or state OUT with `out_ready`=1.
- Arbitration on a grant opportunity:
  - Search starts at `rr_ptr` and wraps; the first i with `req_valid[i]` wins.
  - `req_ready[i]`=1 for the winner only; all others 0.
  - No grant when no request is pending.
  - Outside grant opportunities `req_ready`=0.
  - `rr_ptr` ← winner+1 mod NREQ on every grant, including dropped words.
- Range check at accept:
  - In range: word < `DPS29_RANGE` → `data_q`←word, `id_q`←winner, state→ENC.
  - Out of range: word ≥ `DPS29_RANGE` → word discarded. Next cycle `err_valid`=1 and `err_id`=winner. State→IDLE.
  - `data_q` is not updated on a dropped word.
- Transitions:
  - ENC→OUT unconditionally. The encoder registers `data_q` at this edge; `out_id`←`id_q`.
  - OUT holds while `out_ready`=0. `data_q` is stable, so the free-running encoder register re-captures the same code.
  - OUT with `out_ready`=1: next state follows the new grant (ENC, IDLE, or IDLE with error); IDLE if there is no request.
- `out_valid` = (state==OUT). `out_code` = encoder `codeout`.
- Arithmetic: the range compare is unsigned at `DBLEN29` width. `rr_ptr` wraps at NREQ, not 2^IDW.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `out_valid` 0, `err_valid` 0, `err_id` 0, `out_id` 0, `busy` 0, `data_q` 0, `req_ready` 0.
  - `out_code` is undefined until the first encode; the encoder has no reset. Benches ignore it while `out_valid`=0.
- Latency: a word accepted at edge E has `out_valid`=1 from E+2. Throughput is 1 word per 2 cycles at full rate.
- `out_code`/`out_id` are stable while `out_valid`=1 and `out_ready`=0.
- Same-cycle events in OUT: output handshake and new grant coincide; both complete.
- Error pulse:
  - Lasts exactly 1 cycle.
  - Independent of `out_ready`.
  - Back-to-back bad words produce consecutive pulses.
- Reset mid-operation: the in-flight word is discarded without error indication. Any pending `out_valid` drops next cycle.

## Structure
- `FNS.vh` supplies `DBLEN29` and the FNS constants. Add `DPS29_RANGE` (number of encodable values) and the FSM state encodings (`SCH_IDLE`, `SCH_ENC`, `SCH_OUT`) there.
- One sub-module: a `DPS_encoder_29` instance, connected `datain`←`data_q` and `clock`←`clock`. No other hierarchy; the arbiter stays inline.

## Test plan
- Reset, then single word: requester 2 sends 5 → `req_ready`=4'b0100 that cycle. `out_valid` 2 cycles later with `out_id`=2 and `out_code` equal to a standalone encoder's code for 5. `rr_ptr`=3.
- All four valid continuously with `out_ready`=1 → grants in order 0,1,2,3,0. One output every 2 cycles; `out_id` follows the same order.
- Backpressure: `out_ready`=0 for 6 cycles while OUT → `out_code`/`out_id` constant. `req_ready` all 0. The next grant happens on the `out_ready` rise cycle.
- Range: requester 1 sends `DPS29_RANGE` → `err_valid` pulse, `err_id`=1, no `out_valid`. Requester 1 then sends `DPS29_RANGE`−1 → encoded normally.
- Reset asserted in ENC → next cycle `busy`=0, `out_valid`=0, no error pulse. First post-reset grant goes to the lowest valid index.
- Boundary value 0 and NREQ=3 build: wrap from requester 2 to 0. `out_code`=0 for data 0.
